// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, widths and helpers for the display arbiter
package disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int DISP_DATA_W = 16;
    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;

    // Leading-zero blank mask: a digit is blanked only when it and every
    // more-significant digit are zero. The least-significant digit always shows.
    function automatic logic [DIGITS-1:0] lz_blank(input logic [DISP_DATA_W-1:0] word);
        logic [DIGITS-1:0] mask;
        mask    = '0;
        mask[3] = (word[15:12] == 4'h0);
        mask[2] = mask[3] && (word[11:8] == 4'h0);
        mask[1] = mask[2] && (word[7:4] == 4'h0);
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// rtl/disp_rr_pick.sv - combinational round-robin pick among requesters
//
// Ports:
//   req        in   N_REQ  request levels
//   rr_ptr     in   PW     index searched first
//   exclude    in   N_REQ  requesters removed from the search
//   winner     out  N_REQ  one-hot winner (0 when none)
//   winner_idx out  PW     winner index
//   any        out  1      a winner exists
module disp_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    input  logic [N_REQ-1:0] exclude,
    output logic [N_REQ-1:0] winner,
    output logic [PW-1:0]    winner_idx,
    output logic             any
);

    localparam logic [PW:0] NR = (PW+1)'(N_REQ);

    logic [PW:0]   sum;
    logic [PW-1:0] k;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        sum        = '0;
        k          = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Walk rr_ptr, rr_ptr+1, ... modulo N_REQ; first eligible wins.
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= NR) begin
                sum = sum - NR;
            end
            k = sum[PW-1:0];
            if (!any && req[k] && !exclude[k]) begin
                any        = 1'b1;
                winner[k]  = 1'b1;
                winner_idx = k;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner arbitration and digit scan for a 4-digit display
//
// Optional feature macro: DISP_LZ_BLANK_EN (leading-zero blank mask on blank).
//
// Ports:
//   clk_main   in   1         system clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   req        in   N_REQ     per-requester request level
//   data_in    in   16*N_REQ  requester i word at [16*i+15:16*i]
//   grant      out  N_REQ     one-hot owner, registered
//   disp_data  out  16        displayed word, registered
//   disp_valid out  1         disp_data belongs to a current owner
//   scan_tick  out  1         1-cycle pulse every SCAN_DIV cycles
//   digit_sel  out  2         digit index, advances on scan_tick
//   blank      out  4         per-digit blank mask
module display_arbiter
    import disp_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLD_CYC = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                       clk_main,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [DISP_DATA_W*N_REQ-1:0] data_in,
    output logic [N_REQ-1:0]           grant,
    output logic [DISP_DATA_W-1:0]     disp_data,
    output logic                       disp_valid,
    output logic                       scan_tick,
    output logic [1:0]                 digit_sel,
    output logic [DIGITS-1:0]          blank
);

    localparam int PW = $clog2(N_REQ);
    localparam int DW = $clog2(HOLD_CYC);
    localparam int SW = $clog2(SCAN_DIV);

    localparam logic [DW-1:0] DWELL_RELOAD = DW'(HOLD_CYC - 1);
    localparam logic [SW-1:0] SCAN_LAST    = SW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] LAST_IDX     = PW'(N_REQ - 1);

    arb_state_t              state, state_n;
    logic [PW-1:0]           rr_ptr, rr_ptr_n;
    logic [PW-1:0]           owner, owner_n;
    logic [DW-1:0]           dwell, dwell_n;
    logic [N_REQ-1:0]        grant_n;
    logic                    valid_n;
    logic [DISP_DATA_W-1:0]  data_n;
    logic [SW-1:0]           scan_cnt;

    logic [N_REQ-1:0]        exclude;
    logic [N_REQ-1:0]        pick_winner;
    logic [PW-1:0]           pick_idx;
    logic                    pick_any;
    logic                    take;

    logic [DISP_DATA_W-1:0]  words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign words[g] = data_in[DISP_DATA_W*g +: DISP_DATA_W];
    end

    disp_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .exclude    (exclude),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        owner_n  = owner;
        dwell_n  = dwell;
        rr_ptr_n = rr_ptr;
        valid_n  = disp_valid;
        data_n   = disp_data;
        exclude  = '0;
        take     = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    take = 1'b1;
                end
            end
            HOLD: begin
                // The owner never competes with itself; on a drop its req is
                // already 0, so the mask only matters at dwell expiry.
                exclude = grant;
                if (!req[owner]) begin
                    if (pick_any) begin
                        take = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        valid_n = 1'b0;
                    end
                end else if (dwell == '0) begin
                    if (pick_any) begin
                        take = 1'b1;
                    end else begin
                        dwell_n = DWELL_RELOAD;
                        data_n  = words[owner];
                    end
                end else begin
                    dwell_n = dwell - 1'b1;
                    data_n  = words[owner];
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (take) begin
            state_n  = HOLD;
            grant_n  = pick_winner;
            owner_n  = pick_idx;
            dwell_n  = DWELL_RELOAD;
            rr_ptr_n = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            valid_n  = 1'b1;
            data_n   = words[pick_idx];
        end
    end

    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            dwell      <= '0;
            grant      <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            owner      <= owner_n;
            dwell      <= dwell_n;
            grant      <= grant_n;
            disp_data  <= data_n;
            disp_valid <= valid_n;
        end
    end

    // Free-running scan divider, independent of arbitration.
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
            digit_sel <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b1;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
            scan_tick <= 1'b0;
        end
    end

`ifdef DISP_LZ_BLANK_EN
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else begin
            blank <= valid_n ? lz_blank(data_n) : '0;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed self-checking bench for display_arbiter
module tb_display_arbiter;

    localparam int N_REQ    = 4;
    localparam int HOLD_CYC = 8;
    localparam int SCAN_DIV = 4;

    logic        clk_main = 1'b0;
    logic        rst_n    = 1'b0;
    logic [3:0]  req      = '0;
    logic [63:0] data_in  = '0;
    logic [3:0]  grant;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic        scan_tick;
    logic [1:0]  digit_sel;
    logic [3:0]  blank;

    int checks = 0;
    int errors = 0;

    display_arbiter #(
        .N_REQ    (N_REQ),
        .HOLD_CYC (HOLD_CYC),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk_main   (clk_main),
        .rst_n      (rst_n),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .scan_tick  (scan_tick),
        .digit_sel  (digit_sel),
        .blank      (blank)
    );

    always #5 clk_main = ~clk_main;

    task automatic step();
        @(posedge clk_main);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        data_in = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic       exp_tick;
        logic [1:0] exp_dig;
        rst_n   = 1'b0;
        req     = 4'b1111;
        data_in = 64'h1111_2222_3333_4444;
        step();
        step();
        checks++;
        if ({grant, disp_data, disp_valid, scan_tick, digit_sel, blank} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b data=%h valid=%b tick=%b dig=%0d blank=%b, want all 0",
                     grant, disp_data, disp_valid, scan_tick, digit_sel, blank);
        end
        req     = '0;
        data_in = '0;
        rst_n   = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            exp_tick = (e % 4 == 0);
            exp_dig  = 2'((e / 4) % 4);
            checks++;
            if (scan_tick !== exp_tick || digit_sel !== exp_dig) begin
                errors++;
                $display("FAIL scan_edge%0d: got tick=%b dig=%0d, want tick=%b dig=%0d",
                         e, scan_tick, digit_sel, exp_tick, exp_dig);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req     = 4'b0010;
        data_in = {16'h0, 16'h0, 16'h1234, 16'h0};
        step();
        checks++;
        if (grant !== 4'b0010 || disp_data !== 16'h1234 || disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b data=%h valid=%b, want 0010 1234 1",
                     grant, disp_data, disp_valid);
        end
        data_in = {16'h0, 16'h0, 16'hBEEF, 16'h0};
        step();
        checks++;
        if (disp_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_follow: got data=%h, want beef", disp_data);
        end
        for (int e = 0; e < 20; e++) begin
            step();
            checks++;
            if (grant !== 4'b0010 || disp_valid !== 1'b1 || disp_data !== 16'hBEEF) begin
                errors++;
                $display("FAIL single_hold cyc%0d: got grant=%b valid=%b data=%h, want 0010 1 beef",
                         e, grant, disp_valid, disp_data);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_g;
        logic [15:0] exp_d;
        do_reset();
        data_in = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        req     = 4'b1011;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e <= 8) begin
                exp_g = 4'b0001; exp_d = 16'hA000;
            end else if (e <= 16) begin
                exp_g = 4'b0010; exp_d = 16'hB001;
            end else if (e <= 24) begin
                exp_g = 4'b1000; exp_d = 16'hD003;
            end else begin
                exp_g = 4'b0001; exp_d = 16'hA000;
            end
            checks++;
            if (grant !== exp_g || disp_data !== exp_d || disp_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_edge%0d: got grant=%b data=%h valid=%b, want %b %h 1",
                         e, grant, disp_data, disp_valid, exp_g, exp_d);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        data_in = {16'h4444, 16'h2222, 16'h3333, 16'h1111};
        req     = 4'b0001;
        step();
        step();
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL early_owner: got grant=%b, want 0001", grant);
        end
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || disp_data !== 16'h2222 || disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL early_switch: got grant=%b data=%h valid=%b, want 0100 2222 1",
                     grant, disp_data, disp_valid);
        end
        req     = 4'b0000;
        data_in = {16'h4444, 16'h9999, 16'h3333, 16'h1111};
        step();
        checks++;
        if (grant !== 4'b0000 || disp_valid !== 1'b0 || disp_data !== 16'h2222) begin
            errors++;
            $display("FAIL early_idle: got grant=%b valid=%b data=%h, want 0000 0 2222",
                     grant, disp_valid, disp_data);
        end
        step();
        checks++;
        if (grant !== 4'b0000 || disp_data !== 16'h2222) begin
            errors++;
            $display("FAIL idle_hold: got grant=%b data=%h, want 0000 2222", grant, disp_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        data_in = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
        req     = 4'b0100;
        step();
        step();
        checks++;
        if (grant !== 4'b0100 || disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got grant=%b valid=%b, want 0100 1", grant, disp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || disp_valid !== 1'b0 || disp_data !== 16'h0000) begin
            errors++;
            $display("FAIL async_clear: got grant=%b valid=%b data=%h, want 0000 0 0000",
                     grant, disp_valid, disp_data);
        end
        req = 4'b1010;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0010 || disp_data !== 16'h6666) begin
            errors++;
            $display("FAIL async_rrptr: got grant=%b data=%h, want 0010 6666", grant, disp_data);
        end
    endtask

    task automatic test_blank();
        logic [15:0] vec  [3];
        logic [3:0]  expb [3];
        vec[0] = 16'h0050;
        vec[1] = 16'h0000;
        vec[2] = 16'h1000;
`ifdef DISP_LZ_BLANK_EN
        expb[0] = 4'b1100;
        expb[1] = 4'b1110;
        expb[2] = 4'b0000;
`else
        expb[0] = 4'b0000;
        expb[1] = 4'b0000;
        expb[2] = 4'b0000;
`endif
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            data_in = {48'h0, vec[i]};
            step();
            checks++;
            if (blank !== expb[i] || disp_data !== vec[i]) begin
                errors++;
                $display("FAIL blank_vec%0d: got blank=%b data=%h, want %b %h",
                         i, blank, disp_data, expb[i], vec[i]);
            end
        end
        data_in = {48'h0, 16'h0000};
        step();
        req = 4'b0000;
        step();
        checks++;
        if (blank !== 4'b0000 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL blank_invalid: got blank=%b valid=%b, want 0000 0", blank, disp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_async_reset();
        test_blank();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
